// File: rtl/jtvigil_romarb.sv
// Three-way SDRAM ROM arbiter: scroll-1, scroll-2 and sprites each own a one-word cache.
// A miss is fetched through a single outstanding request slot, granted round-robin.
module jtvigil_romarb #(
  parameter logic [21:0] SCR1_OFFSET = 22'h00000,
  parameter logic [21:0] SCR2_OFFSET = 22'h20000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h60000
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        scr1_cs,
  input  logic [16:0] scr1_addr,
  output logic        scr1_ok,
  output logic [31:0] scr1_data,

  input  logic        scr2_cs,
  input  logic [17:0] scr2_addr,
  output logic        scr2_ok,
  output logic [31:0] scr2_data,

  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic        obj_ok,
  output logic [31:0] obj_data,

  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [31:0] sdram_din
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DST} state_t;

  state_t      state_reg, state_next;
  logic        sdram_req_reg, sdram_req_next;
  logic [21:0] sdram_addr_reg, sdram_addr_next;
  logic [1:0]  grant_reg, grant_next;
  logic [1:0]  last_grant_reg, last_grant_next;
  logic [17:0] addr_lat_reg, addr_lat_next;
  logic        fill;

  // scr1 is widened to 18 bits so all entries share one tag width
  logic [2:0]  cs_vec;
  logic [17:0] addr_vec   [3];
  logic [21:0] offset_vec [3];
  logic [31:0] data_vec   [3];
  logic [2:0]  hit;
  logic [2:0]  pending;

  assign cs_vec        = {obj_cs, scr2_cs, scr1_cs};
  assign addr_vec[0]   = {1'b0, scr1_addr};
  assign addr_vec[1]   = scr2_addr;
  assign addr_vec[2]   = obj_addr;
  assign offset_vec[0] = SCR1_OFFSET;
  assign offset_vec[1] = SCR2_OFFSET;
  assign offset_vec[2] = OBJ_OFFSET;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cache
      logic        valid_reg;
      logic [17:0] tag_reg;
      logic [31:0] data_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
          data_reg  <= '0;
        end else if (fill && grant_reg == 2'(gi)) begin
          valid_reg <= 1'b1;
          tag_reg   <= addr_lat_reg;
          data_reg  <= sdram_din;
        end
      end

      assign hit[gi]      = cs_vec[gi] & valid_reg & (tag_reg == addr_vec[gi]);
      assign pending[gi]  = cs_vec[gi] & ~hit[gi];
      assign data_vec[gi] = data_reg;
    end
  endgenerate

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search starts just after the last granted index
  logic [1:0] pick;
  logic [1:0] cand;
  logic       any_pending;

  always_comb begin
    pick        = 2'd0;
    cand        = last_grant_reg;
    any_pending = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cand = wrap_inc(cand);
      if (!any_pending && pending[cand]) begin
        any_pending = 1'b1;
        pick        = cand;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    sdram_req_next  = sdram_req_reg;
    sdram_addr_next = sdram_addr_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    addr_lat_next   = addr_lat_reg;
    fill            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_pending) begin
          grant_next      = pick;
          addr_lat_next   = addr_vec[pick];
          sdram_addr_next = offset_vec[pick] + {4'd0, addr_vec[pick]};
          sdram_req_next  = 1'b1;
          state_next      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // a dst coinciding with ack belongs to nothing yet and is dropped
        if (sdram_ack) begin
          sdram_req_next = 1'b0;
          state_next     = WAIT_DST;
        end
      end
      WAIT_DST: begin
        if (sdram_dst) begin
          fill            = 1'b1;
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sdram_req_reg  <= 1'b0;
      sdram_addr_reg <= '0;
      grant_reg      <= 2'd0;
      last_grant_reg <= 2'd2;
      addr_lat_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      sdram_req_reg  <= sdram_req_next;
      sdram_addr_reg <= sdram_addr_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      addr_lat_reg   <= addr_lat_next;
    end
  end

  assign sdram_req  = sdram_req_reg;
  assign sdram_addr = sdram_addr_reg;
  assign scr1_ok    = hit[0];
  assign scr2_ok    = hit[1];
  assign obj_ok     = hit[2];
  assign scr1_data  = data_vec[0];
  assign scr2_data  = data_vec[1];
  assign obj_data   = data_vec[2];

endmodule

// File: tb/tb_jtvigil_romarb.sv
// Directed bench for jtvigil_romarb: a cycle table for the basic fetch path
// followed by hand-written round-robin, re-address and reset sequences.
module tb_jtvigil_romarb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scr1_cs = 1'b0, scr2_cs = 1'b0, obj_cs = 1'b0;
  logic [16:0] scr1_addr = '0;
  logic [17:0] scr2_addr = '0, obj_addr = '0;
  logic        scr1_ok, scr2_ok, obj_ok;
  logic [31:0] scr1_data, scr2_data, obj_data;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0, sdram_dst = 1'b0;
  logic [31:0] sdram_din = '0;

  int n_vec = 0;
  int n_err = 0;

  jtvigil_romarb dut (
    .clk(clk), .rst_n(rst_n),
    .scr1_cs(scr1_cs), .scr1_addr(scr1_addr), .scr1_ok(scr1_ok), .scr1_data(scr1_data),
    .scr2_cs(scr2_cs), .scr2_addr(scr2_addr), .scr2_ok(scr2_ok), .scr2_data(scr2_data),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic [2:0]  cs;      // {obj, scr2, scr1}
    logic [16:0] a1;
    logic [17:0] a2;
    logic [17:0] ao;
    logic        ack;
    logic        dst;
    logic [31:0] din;
    logic        e_req;
    logic [21:0] e_addr;
    logic [2:0]  e_ok;    // {obj, scr2, scr1}
    logic [1:0]  dsel;    // 3 = no data check
    logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic [2:0] cs, input logic [16:0] a1,
                              input logic ack, input logic dst, input logic [31:0] din,
                              input logic e_req, input logic [21:0] e_addr, input logic [2:0] e_ok,
                              input logic [1:0] dsel, input logic [31:0] e_data);
    vec_t v;
    v = '{rst_n: r, cs: cs, a1: a1, a2: 18'h0, ao: 18'h0, ack: ack, dst: dst, din: din,
          e_req: e_req, e_addr: e_addr, e_ok: e_ok, dsel: dsel, e_data: e_data};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ok_of(input int n);
    return (n == 0) ? scr1_ok : (n == 1) ? scr2_ok : obj_ok;
  endfunction

  function automatic logic [31:0] data_of(input int n);
    return (n == 0) ? scr1_data : (n == 1) ? scr2_data : obj_data;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    {obj_cs, scr2_cs, scr1_cs} = 3'b000;
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string name, input logic [21:0] exp_addr);
    int n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_req"}, 32'(sdram_req), 32'd1);
    chk({name, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
  endtask

  // ack, one idle cycle, then dst carrying d
  task automatic serve(input string name, input logic [31:0] d);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk({name, "_ackdrop"}, 32'(sdram_req), 32'd0);
    tick();
    sdram_dst = 1'b1;
    sdram_din = d;
    tick();
    sdram_dst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [21:0] rr_exp [6];
    vec_t v;

    // r  cs   a1      ack dst din            req addr     ok    dsel data
    vq.push_back(mk(0, 3'b000, 17'h00, 0, 0, 32'h0,        0, 22'h00, 3'b000, 3, 32'h0));
    vq.push_back(mk(0, 3'b000, 17'h00, 0, 0, 32'h0,        0, 22'h00, 3'b000, 0, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h10, 0, 0, 32'h0,        1, 22'h10, 3'b000, 3, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h10, 0, 0, 32'h0,        1, 22'h10, 3'b000, 3, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h10, 1, 0, 32'h0,        0, 22'h10, 3'b000, 3, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h10, 0, 0, 32'h0,        0, 22'h10, 3'b000, 3, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h10, 0, 0, 32'h0,        0, 22'h10, 3'b000, 3, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h10, 0, 1, 32'hDEADBEEF, 0, 22'h10, 3'b001, 0, 32'hDEADBEEF));
    vq.push_back(mk(1, 3'b001, 17'h10, 0, 0, 32'h0,        0, 22'h10, 3'b001, 0, 32'hDEADBEEF));
    vq.push_back(mk(1, 3'b000, 17'h10, 0, 0, 32'h0,        0, 22'h10, 3'b000, 0, 32'hDEADBEEF));
    vq.push_back(mk(1, 3'b001, 17'h10, 0, 0, 32'h0,        0, 22'h10, 3'b001, 3, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h20, 0, 0, 32'h0,        1, 22'h20, 3'b000, 3, 32'h0));
    vq.push_back(mk(1, 3'b001, 17'h20, 1, 1, 32'h11111111, 0, 22'h20, 3'b000, 0, 32'hDEADBEEF));
    vq.push_back(mk(1, 3'b001, 17'h20, 0, 1, 32'h22222222, 0, 22'h20, 3'b001, 0, 32'h22222222));
    vq.push_back(mk(1, 3'b001, 17'h20, 0, 0, 32'h0,        0, 22'h20, 3'b001, 3, 32'h0));
    vq.push_back(mk(1, 3'b000, 17'h20, 1, 1, 32'h33333333, 0, 22'h20, 3'b000, 0, 32'h22222222));
    vq.push_back(mk(1, 3'b001, 17'h20, 0, 0, 32'h0,        0, 22'h20, 3'b001, 0, 32'h22222222));

    foreach (vq[i]) begin
      v = vq[i];
      rst_n = v.rst_n;
      {obj_cs, scr2_cs, scr1_cs} = v.cs;
      scr1_addr = v.a1;
      scr2_addr = v.a2;
      obj_addr  = v.ao;
      sdram_ack = v.ack;
      sdram_dst = v.dst;
      sdram_din = v.din;
      tick();
      chk($sformatf("v%0d_req", i), 32'(sdram_req), 32'(v.e_req));
      chk($sformatf("v%0d_addr", i), 32'(sdram_addr), 32'(v.e_addr));
      chk($sformatf("v%0d_ok", i), 32'({obj_ok, scr2_ok, scr1_ok}), 32'(v.e_ok));
      if (v.dsel != 2'd3)
        chk($sformatf("v%0d_data", i), data_of(int'(v.dsel)), v.e_data);
      $display("vector %0d: req=%b addr=%h ok=%b", i, sdram_req, sdram_addr,
               {obj_ok, scr2_ok, scr1_ok});
    end
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;

    // Round-robin with all three requesting and re-addressing after each fill
    rr_exp = '{22'h00001, 22'h20002, 22'h60004, 22'h00011, 22'h20012, 22'h60014};
    do_reset();
    scr1_addr = 17'h1;
    scr2_addr = 18'h2;
    obj_addr  = 18'h4;
    {obj_cs, scr2_cs, scr1_cs} = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_req($sformatf("rr%0d", k), rr_exp[k]);
      serve($sformatf("rr%0d", k), 32'hC0DE0000 + 32'(k));
      chk($sformatf("rr%0d_ok", k), 32'(ok_of(k % 3)), 32'd1);
      chk($sformatf("rr%0d_data", k), data_of(k % 3), 32'hC0DE0000 + 32'(k));
      $display("rr grant %0d: addr=%h data=%h", k, rr_exp[k], data_of(k % 3));
      case (k % 3)
        0:       scr1_addr = scr1_addr + 17'h10;
        1:       scr2_addr = scr2_addr + 18'h10;
        default: obj_addr  = obj_addr + 18'h10;
      endcase
    end

    // Address moves while the fetch is in flight
    do_reset();
    scr2_addr = 18'h100;
    scr2_cs = 1'b1;
    wait_req("mv1", 22'h20100);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    scr2_addr = 18'h101;
    tick();
    sdram_dst = 1'b1;
    sdram_din = 32'hAAAA0001;
    tick();
    sdram_dst = 1'b0;
    chk("mv_stale_ok", 32'(scr2_ok), 32'd0);
    wait_req("mv2", 22'h20101);
    serve("mv2", 32'hAAAA0002);
    chk("mv_ok", 32'(scr2_ok), 32'd1);
    chk("mv_data", scr2_data, 32'hAAAA0002);
    $display("readdress: second fetch addr=20101 data=%h", scr2_data);

    // Reset during WAIT_ACK followed by a stray dst
    do_reset();
    scr1_addr = 17'h30;
    scr1_cs = 1'b1;
    wait_req("rs", 22'h00030);
    rst_n = 1'b0;
    tick();
    chk("rs_req", 32'(sdram_req), 32'd0);
    chk("rs_addr", 32'(sdram_addr), 32'd0);
    chk("rs_ok", 32'(scr1_ok), 32'd0);
    rst_n = 1'b1;
    scr1_cs = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 32'h55555555;
    tick();
    sdram_dst = 1'b0;
    chk("rs_stray_req", 32'(sdram_req), 32'd0);
    scr1_cs = 1'b1;
    #1;
    chk("rs_nofill_ok", 32'(scr1_ok), 32'd0);
    scr1_addr = 17'h0;
    #1;
    chk("rs_zero_tag_ok", 32'(scr1_ok), 32'd0);
    tick();
    chk("rs_new_req", 32'(sdram_req), 32'd1);
    chk("rs_new_addr", 32'(sdram_addr), 32'd0);
    $display("reset abort: req=%b addr=%h ok=%b", sdram_req, sdram_addr, scr1_ok);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
